// File: rtl/clk_cntr_checker.sv
// Clock-frequency window checker: per-channel lock FSMs fed by an upstream edge counter,
// Avalon-MM register file and aggregate status LED. Macro CLK_CNTR_CHK_LAST_CNT_EN adds last-count readback.
module clk_cntr_checker #(
  parameter int NR_CH   = 8,
  parameter int CNT_W   = 32,
  parameter int LOCK_N  = 4,
  parameter int BLINK_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             meas_valid,
  input  logic [2:0]       meas_ch,
  input  logic [CNT_W-1:0] meas_cnt,
  input  logic [4:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic [NR_CH-1:0] lock,
  output logic             led_dbg
);

  // state       | meaning
  // ST_UNLOCKED | no qualifying run in progress (also held while disabled)
  // ST_ACQUIRE  | 1..LOCK_N-1 consecutive in-window results seen
  // ST_LOCKED   | LOCK_N or more consecutive in-window results
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  state_t             r_state    [NR_CH];
  state_t             w_state_nx [NR_CH];
  logic [3:0]         r_run      [NR_CH];
  logic [3:0]         w_run_nx   [NR_CH];
  logic [31:0]        r_min      [NR_CH];
  logic [31:0]        r_max      [NR_CH];
  logic [NR_CH-1:0]   r_lost;
  logic [NR_CH-1:0]   w_lost_set;
  logic [NR_CH-1:0]   w_lost_clr;
  logic [NR_CH-1:0]   w_cfg_wr;
  logic [NR_CH-1:0]   w_en;
  logic [NR_CH-1:0]   w_in;
  logic [NR_CH-1:0]   w_hit;
  logic [NR_CH-1:0]   w_lock;
  logic [BLINK_W-1:0] r_blink;
  logic [31:0]        r_rdata;
  logic [31:0]        w_rdata;

`ifdef CLK_CNTR_CHK_LAST_CNT_EN
  logic [CNT_W-1:0]   r_last [NR_CH];
`endif

  always_comb begin
    for (int c = 0; c < NR_CH; c++) begin
      w_cfg_wr[c]   = avs_write && ((avs_address == 5'(c)) || (avs_address == 5'(c + 8)));
      w_en[c]       = (r_max[c] != 32'd0);
      w_hit[c]      = meas_valid && (meas_ch == 3'(c));
      w_in[c]       = (meas_cnt >= CNT_W'(r_min[c])) && (meas_cnt <= CNT_W'(r_max[c]));
      w_lost_clr[c] = avs_write && (avs_address == 5'h11) && avs_writedata[c];
      w_lock[c]     = (r_state[c] == ST_LOCKED);
    end
  end

  // A config write to the channel takes priority over a measurement in the same cycle.
  always_comb begin
    for (int c = 0; c < NR_CH; c++) begin
      w_state_nx[c] = r_state[c];
      w_run_nx[c]   = r_run[c];
      w_lost_set[c] = 1'b0;
      if (w_cfg_wr[c] || !w_en[c]) begin
        w_state_nx[c] = ST_UNLOCKED;
        w_run_nx[c]   = 4'd0;
      end else if (w_hit[c]) begin
        case (r_state[c])
          ST_UNLOCKED: begin
            if (w_in[c]) begin
              w_run_nx[c]   = 4'd1;
              w_state_nx[c] = (LOCK_N == 1) ? ST_LOCKED : ST_ACQUIRE;
            end
          end
          ST_ACQUIRE: begin
            if (w_in[c]) begin
              w_run_nx[c] = (r_run[c] == 4'hF) ? r_run[c] : r_run[c] + 4'd1;
              if (({1'b0, r_run[c]} + 5'd1) >= 5'(LOCK_N))
                w_state_nx[c] = ST_LOCKED;
            end else begin
              w_state_nx[c] = ST_UNLOCKED;
              w_run_nx[c]   = 4'd0;
            end
          end
          ST_LOCKED: begin
            if (!w_in[c]) begin
              w_state_nx[c] = ST_UNLOCKED;
              w_run_nx[c]   = 4'd0;
              w_lost_set[c] = 1'b1;
            end
          end
          default: begin
            w_state_nx[c] = ST_UNLOCKED;
            w_run_nx[c]   = 4'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NR_CH; c++) begin
        r_state[c] <= ST_UNLOCKED;
        r_run[c]   <= 4'd0;
      end
    end else begin
      for (int c = 0; c < NR_CH; c++) begin
        r_state[c] <= w_state_nx[c];
        r_run[c]   <= w_run_nx[c];
      end
    end
  end

  // LOST: a set event in the same cycle beats the W1C clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NR_CH; c++) begin
        r_min[c] <= 32'd0;
        r_max[c] <= 32'd0;
      end
      r_lost <= '0;
    end else begin
      for (int c = 0; c < NR_CH; c++) begin
        if (avs_write && (avs_address == 5'(c)))     r_min[c] <= avs_writedata;
        if (avs_write && (avs_address == 5'(c + 8))) r_max[c] <= avs_writedata;
      end
      r_lost <= w_lost_set | (r_lost & ~w_lost_clr);
    end
  end

`ifdef CLK_CNTR_CHK_LAST_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NR_CH; c++) r_last[c] <= '0;
    end else begin
      for (int c = 0; c < NR_CH; c++) if (w_hit[c]) r_last[c] <= meas_cnt;
    end
  end
`endif

  always_comb begin
    w_rdata = 32'd0;
    for (int c = 0; c < NR_CH; c++) begin
      if (avs_address == 5'(c))      w_rdata = r_min[c];
      if (avs_address == 5'(c + 8))  w_rdata = r_max[c];
`ifdef CLK_CNTR_CHK_LAST_CNT_EN
      if (avs_address == 5'(c + 24)) w_rdata = 32'(r_last[c]);
`endif
    end
    if (avs_address == 5'h10) w_rdata = 32'(w_lock);
    if (avs_address == 5'h11) w_rdata = 32'(r_lost);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= 32'd0;
      r_blink <= '0;
    end else begin
      if (avs_read) r_rdata <= w_rdata;
      r_blink <= r_blink + BLINK_W'(1);
    end
  end

  assign avs_readdata = r_rdata;
  assign lock         = w_lock;
  assign led_dbg      = (w_en == '0)              ? 1'b0 :
                        ((w_lock & w_en) == w_en) ? 1'b1 : r_blink[BLINK_W-1];

endmodule
